sisc_mem_arb: RTL and testbench

Memory-port arbiter and access sequencer for the SISC processor. It shares one single-ported memory between the instruction-fetch requester (IF) and the load/store data requester (D). It grants one requester at a time and holds address, write-enable and write data stable until the memory acknowledges. It also enforces a fetch-starvation bound and a memory timeout. It sits between the control unit's fetch and mem states and the memory model.

---
 rtl/sisc_mem_arb.sv | 121 ++++++++++++
 tb/tb_sisc_mem_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mem_arb.sv
// Memory-port arbiter for SISC: shares one single-ported memory between
// instruction fetch and load/store, with a fetch-starvation bound and an access timeout.
module sisc_mem_arb #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic          err,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int SW = $clog2(STARVE_MAX + 1) + 1;
    localparam int BW = $clog2(TIMEOUT) + 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BUSY_LIM   = BW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_D  = 2'b10
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] busy_cnt;
    logic          fetch_wins;

    // Data normally wins a tie; fetch is forced once it has lost STARVE_MAX times in a row.
    assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy_cnt   <= '0;
            if_gnt     <= 1'b0;
            if_done    <= 1'b0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
            rd_data    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt  <= 1'b0;
            d_gnt   <= 1'b0;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        state      <= BUSY_IF;
                        if_gnt     <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                        busy_cnt   <= '0;
                    end else if (d_req) begin
                        state     <= BUSY_D;
                        d_gnt     <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        busy_cnt  <= '0;
                        if (if_req && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    // An ack on the timeout cycle still counts as a normal completion.
                    if (mem_ack || (busy_cnt == BUSY_LIM)) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == BUSY_IF)
                            if_done <= 1'b1;
                        else
                            d_done <= 1'b1;
                        if (!mem_ack)
                            err <= 1'b1;
                        else if (!mem_we)
                            rd_data <= mem_rdata;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Scoreboard bench for sisc_mem_arb: stimulus pushes expected grant/done events,
// a negedge monitor pops and compares them as the arbiter emits pulses.
module tb_sisc_mem_arb;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_f = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_done, err;
    logic [DW-1:0] rd_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    sisc_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .err(err), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        bit            is_done;
        bit            is_if;
        bit            err;
        logic [AW-1:0] addr;
        bit            we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            total_cnt = 0;
    int            pass_cnt = 0;
    int            cyc = 0;
    int            gnt_cyc = 0;
    int            ack_delay = 0;
    bit            ack_enable = 1'b1;
    bit            stray_ack = 1'b0;
    logic [DW-1:0] mem [0:255];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Memory responder: acks ack_delay BUSY cycles after the access starts.
    initial begin
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
        mem[8'h10] = 32'h1234ABCD;
        forever begin
            @(negedge clk);
            if (mem_en && ack_enable) begin
                if (busy_cycles == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[7:0]] = mem_wdata;
                        mem_rdata = 32'hBAD0BAD0;
                    end else begin
                        mem_rdata = mem[mem_addr[7:0]];
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD1BAD1;
                end
                busy_cycles++;
            end else begin
                busy_cycles = mem_en ? busy_cycles + 1 : 0;
                mem_ack     = stray_ack;
                mem_rdata   = 32'hBAD2BAD2;
            end
        end
    end

    // Monitor: every gnt/done/err pulse must match the next expected event.
    initial forever begin
        @(negedge clk);
        if (if_gnt || d_gnt || if_done || d_done || err) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {28'd0, if_gnt, d_gnt, if_done, d_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!e.is_done) begin
                    checkOutput("gnt_if", 32'(if_gnt), 32'(e.is_if));
                    checkOutput("gnt_d", 32'(d_gnt), 32'(!e.is_if));
                    checkOutput("gnt_mem_en", 32'(mem_en), 32'd1);
                    checkOutput("gnt_mem_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("gnt_mem_we", 32'(mem_we), 32'(e.we));
                    checkOutput("gnt_mem_wdata", mem_wdata, e.wdata);
                    gnt_cyc = cyc;
                end else begin
                    checkOutput("done_if", 32'(if_done), 32'(e.is_if));
                    checkOutput("done_d", 32'(d_done), 32'(!e.is_if));
                    checkOutput("done_err", 32'(err), 32'(e.err));
                    checkOutput("done_rd_data", rd_data, e.rdata);
                    checkOutput("done_mem_en", 32'(mem_en), 32'd0);
                    checkOutput("done_mem_we", 32'(mem_we), 32'd0);
                    checkOutput("done_mem_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("done_latency", cyc - gnt_cyc, e.lat);
                end
            end
        end
    end

    function automatic exp_t mkExp(bit is_done, bit is_if, bit e_err, logic [AW-1:0] addr,
                                   bit we, logic [DW-1:0] wdata, logic [DW-1:0] rdata, int lat);
        exp_t e;
        e.is_done = is_done; e.is_if = is_if; e.err = e_err; e.addr = addr;
        e.we = we; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
        return e;
    endfunction

    // Issue one request (caller is at a negedge); returns at the negedge gnt is seen.
    task automatic applyStimulus(input bit is_if, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                                 input int lat, input bit exp_err, input bit push_done);
        bit got;
        sb.push_back(mkExp(1'b0, is_if, 1'b0, addr, is_if ? 1'b0 : we, is_if ? '0 : wdata, '0, 0));
        if (push_done)
            sb.push_back(mkExp(1'b1, is_if, exp_err, addr, 1'b0, '0, exp_rd, lat));
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_if ? if_gnt : d_gnt) got = 1'b1;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        if (!got) checkOutput("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n_gnt, first_g, last_g;
        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_pulses", {27'd0, if_gnt, d_gnt, if_done, d_done, err}, 32'd0);
        rst_f = 1'b0;
        @(negedge clk);

        // Single fetch with one wait cycle
        ack_delay = 1;
        applyStimulus(1'b1, 1'b0, 16'h0010, '0, 32'h1234ABCD, 2, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fetch_addr_held", 32'(mem_addr), 32'h0010);
        waitDrain();

        // Store then load the same address
        ack_delay = 0;
        applyStimulus(1'b0, 1'b1, 16'h0020, 32'hDEADBEEF, 32'h1234ABCD, 1, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 1'b0, 16'h0020, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b1);
        waitDrain();

        // Starvation: both held, zero-wait memory -> D,D,D,IF,D,D,D,IF
        for (int k = 0; k < 8; k++) begin
            bit f;
            f = (k == 3) || (k == 7);
            sb.push_back(mkExp(1'b0, f, 1'b0, f ? 16'h0030 : 16'h0040, 1'b0, '0, '0, 0));
            sb.push_back(mkExp(1'b1, f, 1'b0, f ? 16'h0030 : 16'h0040, 1'b0, '0,
                               f ? 32'hC0DE0030 : 32'hC0DE0040, 1));
        end
        if_req = 1'b1; if_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040; d_wdata = '0;
        n_gnt = 0; first_g = 0; last_g = 0;
        for (int i = 0; i < 40 && n_gnt < 8; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                if (n_gnt == 0) first_g = cyc;
                last_g = cyc;
                n_gnt++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        checkOutput("starve_grant_count", n_gnt, 32'd8);
        checkOutput("starve_grant_spacing", last_g - first_g, 32'd14);
        waitDrain();

        // Timeout abort, then ack arriving exactly on the timeout cycle
        ack_enable = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0044, 32'h0, 32'hC0DE0030, 15, 1'b1, 1'b1);
        waitDrain();
        ack_enable = 1'b1;
        ack_delay  = 14;
        applyStimulus(1'b0, 1'b0, 16'h0048, 32'h0, 32'hC0DE0048, 15, 1'b0, 1'b1);
        waitDrain();

        // Asynchronous reset in the middle of a store
        ack_enable = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0050, 32'h55AA55AA, '0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_mem_en", 32'(mem_en), 32'd1);
        #2 rst_f = 1'b1;
        #1;
        checkOutput("async_rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("async_rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("async_rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("async_rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_f = 1'b0;
        ack_enable = 1'b1;
        ack_delay = 0;
        repeat (20) @(negedge clk);

        // Stray ack in IDLE must be ignored
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_mem_en", 32'(mem_en), 32'd0);
        checkOutput("stray_rd_data", rd_data, 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0060, '0, 32'hC0DE0060, 1, 1'b0, 1'b1);
        waitDrain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=hung required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
